// File: rtl/cam_alloc_ctrl_if.sv
// Command, response, CAM-port and occupancy signals of the CAM allocation controller.
// Pure wiring: no logic, no latency.
// Backpressure lives in the cmd and rsp valid/ready pairs; the CAM ports are unflow-controlled.
interface cam_alloc_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [1:0]        cmd_op_i;
  logic [DATA_W-1:0] cmd_data_i;
  logic [IDX_W-1:0]  cmd_index_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [1:0]        rsp_status_o;
  logic [IDX_W-1:0]  rsp_index_o;
  logic              cam_write_o;
  logic [IDX_W-1:0]  cam_write_index_o;
  logic [DATA_W-1:0] cam_write_data_o;
  logic              cam_search_o;
  logic [DATA_W-1:0] cam_search_data_o;
  logic              cam_search_valid_i;
  logic [IDX_W-1:0]  cam_search_index_i;
  logic [IDX_W:0]    count_o;
  logic              full_o;
  logic              empty_o;

  // Controller side.
  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_data_i, cmd_index_i, rsp_ready_i,
           cam_search_valid_i, cam_search_index_i,
    output cmd_ready_o, rsp_valid_o, rsp_status_o, rsp_index_o,
           cam_write_o, cam_write_index_o, cam_write_data_o,
           cam_search_o, cam_search_data_o, count_o, full_o, empty_o
  );

  // Requester plus CAM side.
  modport master (
    output cmd_valid_i, cmd_op_i, cmd_data_i, cmd_index_i, rsp_ready_i,
           cam_search_valid_i, cam_search_index_i,
    input  cmd_ready_o, rsp_valid_o, rsp_status_o, rsp_index_o,
           cam_write_o, cam_write_index_o, cam_write_data_o,
           cam_search_o, cam_search_data_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/cam_alloc_ctrl.sv
// Sequences lookup/insert/delete/flush onto a CAM, owning a slot-valid bitmap and lowest-free allocation.
// Latency: delete/flush 1 cycle, lookup/insert-no-write SEARCH_LAT+2, insert-with-write SEARCH_LAT+3.
// One command in flight; cmd_ready_o drops until the response transfers (rsp held until rsp_ready_i).
module cam_alloc_ctrl #(
  parameter int DEPTH      = 32,
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 5,
  parameter int SEARCH_LAT = 1
) (
  input logic            clk_i,
  input logic            rst_i,
  cam_alloc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SRCH, WAIT, WRITE, RESP} state_t;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_MISS = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;
  localparam logic [1:0] ST_DUP  = 2'b11;

  localparam logic [IDX_W:0] DEPTH_C   = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_C     = (IDX_W+1)'(1);
  localparam logic [1:0]     WAIT_INIT = (SEARCH_LAT > 0) ? 2'(SEARCH_LAT - 1) : 2'd0;

  state_t            state;
  logic [1:0]        wait_cnt;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] key_q;
  logic [DEPTH-1:0]  bitmap;
  logic [IDX_W:0]    count;
  logic [IDX_W-1:0]  free_idx;
  logic              accept;
  logic              resolve;
  logic              hit_live;
  logic              hit_stale;

  // Ready is a pure decode of IDLE, forced low while reset is asserted.
  assign bus.cmd_ready_o = (state == IDLE) && !rst_i;
  assign accept          = bus.cmd_valid_i && bus.cmd_ready_o;
  assign bus.count_o     = count;

  // The match result is consumed at the end of the last search/wait cycle.
  assign resolve   = ((state == SRCH) && (SEARCH_LAT == 0)) ||
                     ((state == WAIT) && (wait_cnt == 2'd0));
  // A CAM hit only counts if the slot is still owned; otherwise the row is a leftover.
  assign hit_live  = bus.cam_search_valid_i &&  bitmap[bus.cam_search_index_i];
  assign hit_stale = bus.cam_search_valid_i && !bitmap[bus.cam_search_index_i];

  // Lowest clear bitmap bit; only used when count says a slot is free.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!bitmap[i]) free_idx = IDX_W'(i);
    end
  end

  // Command FSM with all outputs and the occupancy state registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state                 <= IDLE;
      wait_cnt              <= '0;
      op_q                  <= '0;
      key_q                 <= '0;
      bitmap                <= '0;
      count                 <= '0;
      bus.full_o            <= 1'b0;
      bus.empty_o           <= 1'b1;
      bus.rsp_valid_o       <= 1'b0;
      bus.rsp_status_o      <= '0;
      bus.rsp_index_o       <= '0;
      bus.cam_write_o       <= 1'b0;
      bus.cam_write_index_o <= '0;
      bus.cam_write_data_o  <= '0;
      bus.cam_search_o      <= 1'b0;
      bus.cam_search_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= bus.cmd_op_i;
            key_q <= bus.cmd_data_i;
            case (bus.cmd_op_i)
              OP_LOOKUP, OP_INSERT: begin
                state                 <= SRCH;
                bus.cam_search_o      <= 1'b1;
                bus.cam_search_data_o <= bus.cmd_data_i;
              end
              OP_DELETE: begin
                // Deleting only clears ownership; the CAM row is left to go stale.
                if (bitmap[bus.cmd_index_i]) begin
                  bitmap[bus.cmd_index_i] <= 1'b0;
                  count                   <= count - ONE_C;
                  bus.full_o              <= 1'b0;
                  bus.empty_o             <= (count == ONE_C);
                  bus.rsp_status_o        <= ST_OK;
                end else begin
                  bus.rsp_status_o        <= ST_MISS;
                end
                bus.rsp_index_o <= bus.cmd_index_i;
                bus.rsp_valid_o <= 1'b1;
                state           <= RESP;
              end
              default: begin
                bitmap           <= '0;
                count            <= '0;
                bus.full_o       <= 1'b0;
                bus.empty_o      <= 1'b1;
                bus.rsp_status_o <= ST_OK;
                bus.rsp_index_o  <= '0;
                bus.rsp_valid_o  <= 1'b1;
                state            <= RESP;
              end
            endcase
          end
        end
        SRCH: begin
          bus.cam_search_o <= 1'b0;
          if (SEARCH_LAT != 0) begin
            state    <= WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
        end
        WRITE: begin
          bus.cam_write_o                <= 1'b0;
          bitmap[bus.cam_write_index_o]  <= 1'b1;
          count                          <= count + ONE_C;
          bus.full_o                     <= ((count + ONE_C) == DEPTH_C);
          bus.empty_o                    <= 1'b0;
          bus.rsp_status_o               <= ST_OK;
          bus.rsp_index_o                <= bus.cam_write_index_o;
          bus.rsp_valid_o                <= 1'b1;
          state                          <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Search outcome; overrides the per-state next state above.
      if (resolve) begin
        bus.cam_search_data_o <= '0;
        if (op_q == OP_LOOKUP) begin
          bus.rsp_status_o <= hit_live ? ST_OK : ST_MISS;
          bus.rsp_index_o  <= hit_live ? bus.cam_search_index_i : '0;
          bus.rsp_valid_o  <= 1'b1;
          state            <= RESP;
        end else if (hit_live) begin
          bus.rsp_status_o <= ST_DUP;
          bus.rsp_index_o  <= bus.cam_search_index_i;
          bus.rsp_valid_o  <= 1'b1;
          state            <= RESP;
        end else if (hit_stale) begin
          // Overwrite the leftover row so the key never exists twice in the CAM.
          bus.cam_write_o       <= 1'b1;
          bus.cam_write_index_o <= bus.cam_search_index_i;
          bus.cam_write_data_o  <= key_q;
          state                 <= WRITE;
        end else if (count != DEPTH_C) begin
          bus.cam_write_o       <= 1'b1;
          bus.cam_write_index_o <= free_idx;
          bus.cam_write_data_o  <= key_q;
          state                 <= WRITE;
        end else begin
          bus.rsp_status_o <= ST_FULL;
          bus.rsp_index_o  <= '0;
          bus.rsp_valid_o  <= 1'b1;
          state            <= RESP;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Randomized and directed bench for cam_alloc_ctrl against a table-level reference model.
// Includes a behavioural CAM that answers searches one cycle after cam_search_o.
// Response backpressure is exercised with random rsp_ready_i holds.
module tb_cam_alloc_ctrl;
  localparam int L = 1;
  localparam int N = 32;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cam_alloc_ctrl_if #(.DATA_W(32), .IDX_W(5)) bus ();

  cam_alloc_ctrl #(.DEPTH(N), .DATA_W(32), .IDX_W(5), .SEARCH_LAT(L)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural CAM: rows persist across controller reset and flush.
  logic [31:0] cam_rows [N];
  logic [31:0] cam_used = '0;
  always @(posedge clk) begin : cam_env
    logic       h;
    logic [4:0] hi;
    if (bus.cam_write_o) begin
      cam_rows[bus.cam_write_index_o] <= bus.cam_write_data_o;
      cam_used[bus.cam_write_index_o] <= 1'b1;
    end
    if (bus.cam_search_o) begin
      h  = 1'b0;
      hi = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (cam_used[i] && cam_rows[i] == bus.cam_search_data_o) begin
          h  = 1'b1;
          hi = 5'(i);
        end
      end
      bus.cam_search_valid_i <= h;
      bus.cam_search_index_i <= hi;
    end
  end

  // Reference model: which slots the table owns and what each physical row holds.
  bit [31:0] m_valid;
  bit [31:0] m_key [N];
  bit [31:0] m_used;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  task automatic model(input logic [1:0] op, input logic [31:0] key, input logic [4:0] idx,
                       output logic [1:0] st, output logic [4:0] ix, output bit wr, output int lat);
    int row = -1;
    int fr  = -1;
    wr = 0;
    ix = '0;
    for (int i = 0; i < N; i++) if (row < 0 && m_used[i] && m_key[i] == key) row = i;
    for (int i = 0; i < N; i++) if (fr < 0 && !m_valid[i]) fr = i;
    case (op)
      OP_LOOKUP: begin
        lat = L + 2;
        if (row >= 0 && m_valid[row]) begin st = 2'b00; ix = 5'(row); end
        else st = 2'b01;
      end
      OP_INSERT: begin
        lat = L + 2;
        if (row >= 0 && m_valid[row]) begin st = 2'b11; ix = 5'(row); end
        else begin
          if (row < 0) row = fr;
          if (row < 0) st = 2'b10;
          else begin
            st = 2'b00; ix = 5'(row); wr = 1; lat = L + 3;
            m_valid[row] = 1'b1; m_key[row] = key; m_used[row] = 1'b1;
          end
        end
      end
      OP_DELETE: begin
        lat = 1; ix = idx;
        st  = m_valid[idx] ? 2'b00 : 2'b01;
        m_valid[idx] = 1'b0;
      end
      default: begin
        lat = 1; st = 2'b00; m_valid = '0;
      end
    endcase
  endtask

  // Issue one command and check everything up to and including the response transfer.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] key, input logic [4:0] idx,
                         input int hold);
    logic [1:0] est;
    logic [4:0] eix;
    bit         ewr;
    int         elat, cyc, srch_n, srch_c, wr_n, wr_c;
    logic [4:0] wr_i;
    logic [31:0] wr_d;
    model(op, key, idx, est, eix, ewr, elat);
    chk("cmd_ready_idle", 64'(bus.cmd_ready_o), 64'(1));
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_data_i  = key;
    bus.cmd_index_i = idx;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_data_i  = $urandom;
    bus.cmd_index_i = 5'($urandom_range(0, 31));
    chk("cmd_ready_busy", 64'(bus.cmd_ready_o), 64'(0));
    srch_n = 0; srch_c = 0; wr_n = 0; wr_c = 0; wr_i = '0; wr_d = '0;
    for (cyc = 1; cyc < 40; cyc++) begin
      if (bus.cam_search_o) begin srch_n++; srch_c = cyc; end
      if (bus.cam_write_o) begin wr_n++; wr_c = cyc; wr_i = bus.cam_write_index_o; wr_d = bus.cam_write_data_o; end
      if (bus.cam_search_o && bus.cam_write_o) chk("search_write_overlap", 64'(1), 64'(0));
      if ((bus.cam_search_o || (cyc > 1 && cyc <= L + 1)) && bus.cam_search_data_o !== key)
        chk("search_key", 64'(bus.cam_search_data_o), 64'(key));
      if (bus.rsp_valid_o) break;
      @(negedge clk);
    end
    chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(1));
    chk("rsp_latency", 64'(cyc), 64'(elat));
    chk("rsp_status", 64'(bus.rsp_status_o), 64'(est));
    chk("rsp_index", 64'(bus.rsp_index_o), 64'(eix));
    chk("search_pulses", 64'(srch_n), 64'((op == OP_LOOKUP || op == OP_INSERT) ? 1 : 0));
    if (srch_n > 0) chk("search_cycle", 64'(srch_c), 64'(1));
    chk("write_pulses", 64'(wr_n), 64'(ewr));
    if (ewr) begin
      chk("write_index", 64'(wr_i), 64'(eix));
      chk("write_data", 64'(wr_d), 64'(key));
      chk("write_cycle", 64'(wr_c), 64'(L + 2));
    end
    // While the response is held, offer a flush that must not be taken.
    for (int h = 0; h < hold; h++) begin
      bus.cmd_valid_i = 1'b1;
      bus.cmd_op_i    = OP_FLUSH;
      @(negedge clk);
      chk("hold_valid", 64'(bus.rsp_valid_o), 64'(1));
      chk("hold_status", 64'(bus.rsp_status_o), 64'(est));
      chk("hold_index", 64'(bus.rsp_index_o), 64'(eix));
      chk("hold_ready", 64'(bus.cmd_ready_o), 64'(0));
    end
    bus.cmd_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    chk("rsp_dropped", 64'(bus.rsp_valid_o), 64'(0));
    chk("count", 64'(bus.count_o), 64'(m_count()));
    chk("full", 64'(bus.full_o), 64'(m_count() == N));
    chk("empty", 64'(bus.empty_o), 64'(m_count() == 0));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready_o), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'(0));
    chk({tag, "_rsp_status"}, 64'(bus.rsp_status_o), 64'(0));
    chk({tag, "_rsp_index"}, 64'(bus.rsp_index_o), 64'(0));
    chk({tag, "_cam_write"}, 64'(bus.cam_write_o), 64'(0));
    chk({tag, "_cam_search"}, 64'(bus.cam_search_o), 64'(0));
    chk({tag, "_search_data"}, 64'(bus.cam_search_data_o), 64'(0));
    chk({tag, "_count"}, 64'(bus.count_o), 64'(0));
    chk({tag, "_full"}, 64'(bus.full_o), 64'(0));
    chk({tag, "_empty"}, 64'(bus.empty_o), 64'(1));
  endtask

  task automatic rand_cmds(input int n);
    logic [1:0] op;
    int         r;
    for (int k = 0; k < n; k++) begin
      r  = $urandom_range(0, 99);
      op = (r < 30) ? OP_LOOKUP : (r < 72) ? OP_INSERT : (r < 95) ? OP_DELETE : OP_FLUSH;
      run_cmd(op, 32'hA500_0000 + 32'($urandom_range(0, 47)), 5'($urandom_range(0, 31)),
              $urandom_range(0, 3));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_valid = '0;
    m_used  = '0;
    rst = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = '0;
    bus.cmd_data_i  = '0;
    bus.cmd_index_i = '0;
    bus.rsp_ready_i = 1'b0;
    #1;
    chk_reset("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_release", 64'(bus.cmd_ready_o), 64'(1));

    // First insert lands in slot 0 with full latency; repeat is a duplicate.
    run_cmd(OP_INSERT, 32'hDEADBEEF, 5'd0, 0);
    run_cmd(OP_INSERT, 32'hDEADBEEF, 5'd0, 1);

    // Fill all 32 slots, then overflow.
    run_cmd(OP_FLUSH, 32'h0, 5'd0, 0);
    for (int i = 0; i < N; i++) run_cmd(OP_INSERT, 32'h1000 + 32'(i), 5'd0, 0);
    run_cmd(OP_INSERT, 32'h2000, 5'd0, 0);

    // Delete leaves a stale row: lookup misses, re-insert reuses slot 5.
    run_cmd(OP_DELETE, 32'h0, 5'd5, 0);
    run_cmd(OP_LOOKUP, 32'h1005, 5'd0, 0);
    run_cmd(OP_INSERT, 32'h1005, 5'd0, 0);
    run_cmd(OP_LOOKUP, 32'h1007, 5'd0, 0);

    // Flush with ten entries, then everything misses.
    run_cmd(OP_FLUSH, 32'h0, 5'd0, 0);
    for (int i = 0; i < 10; i++) run_cmd(OP_INSERT, 32'h3000 + 32'(i), 5'd0, 0);
    run_cmd(OP_FLUSH, 32'h0, 5'd0, 0);
    run_cmd(OP_LOOKUP, 32'h3002, 5'd0, 0);
    run_cmd(OP_DELETE, 32'h0, 5'd3, 0);

    // Long response hold.
    run_cmd(OP_INSERT, 32'h4444, 5'd0, 5);
    run_cmd(OP_LOOKUP, 32'h4444, 5'd0, 5);

    rand_cmds(400);

    // Reset while the insert is waiting on the CAM.
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = OP_INSERT;
    bus.cmd_data_i  = 32'h5555_0001;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset("abort");
    @(negedge clk);
    chk_reset("abort_next");
    rst = 1'b0;
    m_valid = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 64'(bus.rsp_valid_o), 64'(0));
      chk("abort_no_write", 64'(bus.cam_write_o), 64'(0));
    end
    rand_cmds(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
